// File: rtl/psg_pkg.sv
// Package psg_pkg: shared definitions for programmable_sequence_generator.
// Holds the default width constants and the FSM state enum.
// Configuration macro PSG_GAP_EN: when defined, a GAP state is added.
package psg_pkg;

  localparam int unsigned SEQ_W_DEF = 5;
  localparam int unsigned REP_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_FIN  = 2'd2
`ifdef PSG_GAP_EN
    ,
    ST_GAP  = 2'd3
`endif
  } psg_state_e;

endpackage

// File: rtl/programmable_sequence_generator_if.sv
// Interface bundling the request and serial-output signals of
// programmable_sequence_generator.
//   master: drives start/abort/init/reps, observes dout/dout_valid/busy/done
//   slave : the generator itself
interface programmable_sequence_generator_if
  import psg_pkg::*;
#(
  parameter int unsigned SEQ_W = SEQ_W_DEF,
  parameter int unsigned REP_W = REP_W_DEF
);

  logic             start;
  logic             abort;
  logic [SEQ_W-1:0] init;
  logic [REP_W-1:0] reps;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, init, reps,
    input  dout, dout_valid, busy, done
  );

  modport slave (
    input  start, abort, init, reps,
    output dout, dout_valid, busy, done
  );

endinterface

// File: rtl/psg_shifter.sv
// psg_shifter: loadable left-shift pattern register with a bit counter.
//   clk, resetn : clock, synchronous active-low reset
//   load        : capture init into the working and reload copies
//   shift       : advance one bit; at the pattern boundary reload from the copy
//   init        : pattern to capture
//   last        : the current bit is the final bit of the pattern
//   next_msb    : MSB of the register after this edge (feeds the output flop)
module psg_shifter
  import psg_pkg::*;
#(
  parameter int unsigned SEQ_W = SEQ_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             shift,
  input  logic [SEQ_W-1:0] init,
  output logic             last,
  output logic             next_msb
);

  localparam int unsigned CNT_W = (SEQ_W > 1) ? $clog2(SEQ_W) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(SEQ_W - 1);

  logic [SEQ_W-1:0] pat_q, pat_d;
  logic [SEQ_W-1:0] cap_q, cap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == '0);

  always_comb begin
    pat_d = pat_q;
    cap_d = cap_q;
    cnt_d = cnt_q;
    if (load) begin
      pat_d = init;
      cap_d = init;
      cnt_d = CNT_TOP;
    end else if (shift) begin
      if (last) begin
        pat_d = cap_q;
        cnt_d = CNT_TOP;
      end else begin
        pat_d = pat_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  assign next_msb = pat_d[SEQ_W-1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pat_q <= '0;
      cap_q <= '0;
      cnt_q <= '0;
    end else begin
      pat_q <= pat_d;
      cap_q <= cap_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/programmable_sequence_generator.sv
// programmable_sequence_generator: transmits a captured SEQ_W-bit pattern
// MSB first, (reps+1) times, then pulses done for one cycle.
//   clk, resetn : clock, synchronous active-low reset
//   bus (slave) : start, abort, init, reps in; dout, dout_valid, busy, done out
// Macro PSG_GAP_EN: insert one idle GAP cycle between repetitions.
module programmable_sequence_generator
  import psg_pkg::*;
#(
  parameter int unsigned SEQ_W = SEQ_W_DEF,
  parameter int unsigned REP_W = REP_W_DEF
) (
  input  logic                              clk,
  input  logic                              resetn,
  programmable_sequence_generator_if.slave  bus
);

  psg_state_e       state_q, state_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic load;
  logic shift;
  logic last;
  logic next_msb;

  assign load  = (state_q == ST_IDLE) && bus.start && !bus.abort;
  assign shift = (state_q == ST_SEND);

  psg_shifter #(.SEQ_W(SEQ_W)) u_shifter (
    .clk      (clk),
    .resetn   (resetn),
    .load     (load),
    .shift    (shift),
    .init     (bus.init),
    .last     (last),
    .next_msb (next_msb)
  );

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SEND;
          rep_d   = bus.reps;
        end
      end
      ST_SEND: begin
        if (last) begin
          if (rep_q != '0) begin
            rep_d = rep_q - REP_W'(1);
`ifdef PSG_GAP_EN
            state_d = ST_GAP;
`endif
          end else begin
            state_d = ST_FIN;
          end
        end
      end
`ifdef PSG_GAP_EN
      ST_GAP:  state_d = ST_SEND;
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.abort) state_d = ST_IDLE;
  end

  // Outputs are registered: decoded from the next state so they line up with
  // the state they describe.
  always_comb begin
    dout_valid_d = (state_d == ST_SEND);
    dout_d       = dout_valid_d && next_msb;
    busy_d       = (state_d == ST_SEND)
`ifdef PSG_GAP_EN
                   || (state_d == ST_GAP)
`endif
                   ;
    done_d       = (state_d == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      rep_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rep_q        <= rep_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
